// File: rtl/flow_ctrl_mc.sv
// flow_ctrl_mc: multi-channel FIFO flow-control controller.
// Compares NUM_CH occupancy counts against programmable almost-full and
// almost-empty thresholds. Drives per-channel pause/resume with hysteresis
// and the global IDLE / ERROR / flush sequencing.
//
// Ports:
//   clk        - clock; all state updates happen on the rising edge
//   reset      - asynchronous, active-low reset
//   iniciar    - start request, sampled only in INIT
//   occ        - packed occupancy counts; channel i is at [i*CNT_W +: CNT_W]
//   umbral_af  - almost-full threshold
//   umbral_ae  - almost-empty threshold
//   err_clear  - clears error_ch
//   pausa      - per-channel pause level
//   continuar  - per-channel one-cycle resume pulse
//   idle       - high while in IDLE
//   error_full - high while in ERROR or RST
//   flush      - one-cycle pulse in RST that tells the FIFOs to empty
//   error_ch   - sticky set of the channels that were full on ERROR entry
//   err_cnt    - saturating count of ERROR entries
//   estado     - current state code
module flow_ctrl_mc #(
    parameter int NUM_CH   = 4,
    parameter int DEPTH    = 16,
    parameter int CNT_W    = 5,
    parameter int ERR_HOLD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [NUM_CH*CNT_W-1:0] occ,
    input  logic [CNT_W-1:0]        umbral_af,
    input  logic [CNT_W-1:0]        umbral_ae,
    input  logic                    err_clear,
    output logic [NUM_CH-1:0]       pausa,
    output logic [NUM_CH-1:0]       continuar,
    output logic                    idle,
    output logic                    error_full,
    output logic                    flush,
    output logic [NUM_CH-1:0]       error_ch,
    output logic [7:0]              err_cnt,
    output logic [2:0]              estado
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_ACTIVE = 3'd2,
        S_ERROR  = 3'd3,
        S_RST    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
    localparam logic [3:0]       L_HOLD  = 4'(ERR_HOLD);

    state_t              r_state;
    logic [3:0]          r_hold;
    logic [NUM_CH-1:0]   r_pausa;
    logic [NUM_CH-1:0]   r_cont;
    logic                r_idle;
    logic                r_efull;
    logic                r_flush;
    logic [NUM_CH-1:0]   r_ech;
    logic [7:0]          r_cnt;

    logic [NUM_CH-1:0]   w_full;
    logic [NUM_CH-1:0]   w_af;
    logic [NUM_CH-1:0]   w_ae;
    logic [NUM_CH-1:0]   w_empty;
    logic                w_any_full;
    logic                w_all_empty;
    state_t              w_next;
    logic                w_enter_err;
    logic [NUM_CH-1:0]   w_pausa_nx;
    logic [NUM_CH-1:0]   w_cont_nx;

    // Per-channel occupancy flags
    always_comb begin
        w_full  = '0;
        w_af    = '0;
        w_ae    = '0;
        w_empty = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_full[i]  = (occ[i*CNT_W +: CNT_W] == L_DEPTH);
            w_af[i]    = (occ[i*CNT_W +: CNT_W] >= umbral_af);
            w_ae[i]    = (occ[i*CNT_W +: CNT_W] <= umbral_ae);
            w_empty[i] = (occ[i*CNT_W +: CNT_W] == '0);
        end
    end

    assign w_any_full  = |w_full;
    assign w_all_empty = &w_empty;

    // Next-state selection; undefined codes fall back to INIT
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = iniciar ? S_IDLE : S_INIT;
            S_IDLE:   w_next = w_any_full ? S_ERROR :
                               (!w_all_empty ? S_ACTIVE : S_IDLE);
            S_ACTIVE: w_next = w_any_full ? S_ERROR :
                               (w_all_empty ? S_IDLE : S_ACTIVE);
            // r_hold counts ERROR cycles starting at 1 on the entry edge
            S_ERROR:  w_next = (r_hold >= L_HOLD) ? S_RST : S_ERROR;
            S_RST:    w_next = S_IDLE;
            default:  w_next = S_INIT;
        endcase
    end

    assign w_enter_err = (w_next == S_ERROR) && (r_state != S_ERROR);

    // Pause hysteresis: set has priority over clear when thresholds overlap.
    // A jump to ERROR drops every pause without a resume pulse.
    always_comb begin
        w_pausa_nx = r_pausa;
        w_cont_nx  = '0;
        if (r_state == S_ACTIVE) begin
            if (w_any_full) begin
                w_pausa_nx = '0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!r_pausa[i] && w_af[i]) begin
                        w_pausa_nx[i] = 1'b1;
                    end else if (r_pausa[i] && w_ae[i] && !w_af[i]) begin
                        w_pausa_nx[i] = 1'b0;
                        w_cont_nx[i]  = 1'b1;
                    end
                end
            end
        end
    end

    // State register, hold counter and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_hold  <= '0;
            r_pausa <= '0;
            r_cont  <= '0;
            r_idle  <= 1'b0;
            r_efull <= 1'b0;
            r_flush <= 1'b0;
            r_ech   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == S_IDLE);
            r_efull <= (w_next == S_ERROR) || (w_next == S_RST);
            r_flush <= (w_next == S_RST);
            r_pausa <= w_pausa_nx;
            r_cont  <= w_cont_nx;

            if (w_enter_err) begin
                r_hold <= 4'd1;
            end else if (r_state == S_ERROR) begin
                r_hold <= r_hold + 4'd1;
            end else begin
                r_hold <= '0;
            end

            // Capture beats a coincident clear
            if (w_enter_err) begin
                r_ech <= r_ech | w_full;
            end else if (err_clear) begin
                r_ech <= '0;
            end

            if (w_enter_err && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign pausa      = r_pausa;
    assign continuar  = r_cont;
    assign idle       = r_idle;
    assign error_full = r_efull;
    assign flush      = r_flush;
    assign error_ch   = r_ech;
    assign err_cnt    = r_cnt;
    assign estado     = r_state;

endmodule

// File: tb/tb_flow_ctrl_mc.sv
// Testbench for flow_ctrl_mc: table of {inputs, expected outputs} rows applied
// one clock edge per row, expected values queued on drive and popped on check,
// followed by an asynchronous reset check in the middle of ERROR.
module tb_flow_ctrl_mc;

    localparam int NUM_CH   = 4;
    localparam int DEPTH    = 16;
    localparam int CNT_W    = 5;
    localparam int ERR_HOLD = 2;

    logic                    clk;
    logic                    reset;
    logic                    iniciar;
    logic [NUM_CH*CNT_W-1:0] occ;
    logic [CNT_W-1:0]        umbral_af;
    logic [CNT_W-1:0]        umbral_ae;
    logic                    err_clear;
    logic [NUM_CH-1:0]       pausa;
    logic [NUM_CH-1:0]       continuar;
    logic                    idle;
    logic                    error_full;
    logic                    flush;
    logic [NUM_CH-1:0]       error_ch;
    logic [7:0]              err_cnt;
    logic [2:0]              estado;

    flow_ctrl_mc #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(CNT_W), .ERR_HOLD(ERR_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .occ(occ),
        .umbral_af(umbral_af), .umbral_ae(umbral_ae), .err_clear(err_clear),
        .pausa(pausa), .continuar(continuar), .idle(idle),
        .error_full(error_full), .flush(flush), .error_ch(error_ch),
        .err_cnt(err_cnt), .estado(estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                    ini;
        logic [NUM_CH*CNT_W-1:0] occ;
        logic [CNT_W-1:0]        af;
        logic [CNT_W-1:0]        ae;
        logic                    clr;
        logic [2:0]              st;
        logic                    idle;
        logic                    efull;
        logic                    flush;
        logic [NUM_CH-1:0]       pa;
        logic [NUM_CH-1:0]       co;
        logic [NUM_CH-1:0]       ech;
        logic [7:0]              cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [NUM_CH*CNT_W-1:0] P(input int o0, input int o1,
                                                  input int o2, input int o3);
        return {CNT_W'(o3), CNT_W'(o2), CNT_W'(o1), CNT_W'(o0)};
    endfunction

    task automatic add(input logic ini, input logic [NUM_CH*CNT_W-1:0] o,
                       input int af, input int ae, input logic clr,
                       input int st, input logic id, input logic ef,
                       input logic fl, input logic [3:0] pa, input logic [3:0] co,
                       input logic [3:0] ech, input int cnt);
        vec_t v;
        v.ini = ini; v.occ = o; v.af = CNT_W'(af); v.ae = CNT_W'(ae); v.clr = clr;
        v.st = 3'(st); v.idle = id; v.efull = ef; v.flush = fl;
        v.pa = pa; v.co = co; v.ech = ech; v.cnt = 8'(cnt);
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic check_all(input int row, input vec_t e);
        chk("estado",     row, 32'(estado),     32'(e.st));
        chk("idle",       row, 32'(idle),       32'(e.idle));
        chk("error_full", row, 32'(error_full), 32'(e.efull));
        chk("flush",      row, 32'(flush),      32'(e.flush));
        chk("pausa",      row, 32'(pausa),      32'(e.pa));
        chk("continuar",  row, 32'(continuar),  32'(e.co));
        chk("error_ch",   row, 32'(error_ch),   32'(e.ech));
        chk("err_cnt",    row, 32'(err_cnt),    32'(e.cnt));
    endtask

    initial begin
        vec_t zero;
        int   c;
        zero = '{ini:0, occ:'0, af:'0, ae:'0, clr:0, st:0, idle:0, efull:0,
                 flush:0, pa:'0, co:'0, ech:'0, cnt:'0};

        //   ini occ              af  ae clr st id ef fl pausa    cont     ech      cnt
        add(0, P(0,0,0,0),       12, 4, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(1, P(0,0,0,0),       12, 4, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, P(0,0,0,0),       12, 4, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, P(3,0,0,0),       12, 4, 0, 2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, P(3,5,0,0),       12, 4, 0, 2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, P(3,11,0,0),      12, 4, 0, 2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        add(0, P(3,12,0,0),      12, 4, 0, 2, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0);
        add(0, P(3,8,0,0),       12, 4, 0, 2, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0);
        add(0, P(3,5,0,0),       12, 4, 0, 2, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0);
        add(0, P(3,4,0,0),       12, 4, 0, 2, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0);
        add(0, P(3,13,0,0),      12, 4, 0, 2, 0, 0, 0, 4'b0010, 4'b0000, 4'b0000, 0);
        // two channels full, clear coincident with capture
        add(0, P(3,13,16,16),    12, 4, 1, 3, 0, 1, 0, 4'b0000, 4'b0000, 4'b1100, 1);
        add(0, P(3,13,16,16),    12, 4, 0, 3, 0, 1, 0, 4'b0000, 4'b0000, 4'b1100, 1);
        add(0, P(3,13,16,16),    12, 4, 0, 4, 0, 1, 1, 4'b0000, 4'b0000, 4'b1100, 1);
        add(0, P(0,0,0,0),       12, 4, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b1100, 1);
        add(0, P(0,0,0,0),       12, 4, 1, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        // overlapping thresholds: ae=10 > af=8
        add(0, P(9,0,0,0),        8, 10, 0, 2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, P(9,0,0,0),        8, 10, 0, 2, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
        add(0, P(8,0,0,0),        8, 10, 0, 2, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
        add(0, P(7,0,0,0),        8, 10, 0, 2, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1);
        add(0, P(0,0,0,0),        8, 10, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        // ACTIVE->IDLE releases a set pause with a resume pulse
        add(0, P(13,0,0,0),      12, 4, 0, 2, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        add(0, P(13,0,0,0),      12, 4, 0, 2, 0, 0, 0, 4'b0001, 4'b0000, 4'b0000, 1);
        add(0, P(0,0,0,0),       12, 4, 0, 1, 1, 0, 0, 4'b0000, 4'b0001, 4'b0000, 1);

        // repeated IDLE->ERROR->ERROR->RST->IDLE cycles to saturate err_cnt
        c = 1;
        for (int k = 0; k < 260; k++) begin
            c = (c < 255) ? c + 1 : 255;
            add(0, P(16,0,0,0), 12, 4, 0, 3, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, c);
            add(0, P(16,0,0,0), 12, 4, 0, 3, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, c);
            add(0, P(16,0,0,0), 12, 4, 0, 4, 0, 1, 1, 4'b0000, 4'b0000, 4'b0001, c);
            add(0, P(16,0,0,0), 12, 4, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 4'b0001, c);
        end
        add(0, P(16,0,0,0), 12, 4, 0, 3, 0, 1, 0, 4'b0000, 4'b0000, 4'b0001, 255);

        reset     = 1'b0;
        iniciar   = 1'b0;
        occ       = '0;
        umbral_af = 5'd12;
        umbral_ae = 5'd4;
        err_clear = 1'b0;
        #12;
        check_all(-1, zero);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            iniciar   = tbl[r].ini;
            occ       = tbl[r].occ;
            umbral_af = tbl[r].af;
            umbral_ae = tbl[r].ae;
            err_clear = tbl[r].clr;
            exp_q.push_back(tbl[r]);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("queue_empty", r, 32'(exp_q.size()), 32'd1);
            end else begin
                check_all(r, exp_q.pop_front());
            end
        end

        // async reset in the middle of ERROR, between clock edges
        #2;
        reset = 1'b0;
        #1;
        check_all(-2, zero);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/flow_ctrl_mc.md
Name: flow_ctrl_mc

Overview:
Parametrised multi-channel flow-control controller, the successor to the single-channel flag-driven FSM. It watches NUM_CH FIFO occupancy counts against runtime-programmable thresholds. It drives per-channel pause/continue with hysteresis, plus the global idle, error and flush control. It sits between the FIFO bank and the upstream data sources.

Parameters:
NUM_CH, 4, number of monitored FIFO channels (1..8)
DEPTH, 16, FIFO depth; a channel is full when its occupancy equals DEPTH
CNT_W, 5, occupancy/threshold width; must satisfy 2^CNT_W > DEPTH
ERR_HOLD, 2, cycles spent in ERROR before RST (1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
iniciar  in  1  start request, sampled only in INIT
occ  in  NUM_CH*CNT_W  packed occupancy counts, channel i at [i*CNT_W +: CNT_W]
umbral_af  in  CNT_W  almost-full threshold
umbral_ae  in  CNT_W  almost-empty threshold
err_clear  in  1  clears error_ch
pausa  out  NUM_CH  per-channel pause level
continuar  out  NUM_CH  per-channel one-cycle resume pulse
idle  out  1  high in IDLE
error_full  out  1  high in ERROR and RST
flush  out  1  one-cycle pulse in RST, tells the FIFOs to empty
error_ch  out  NUM_CH  sticky record of the channels that were full on ERROR entry
err_cnt  out  8  saturating count of ERROR entries
estado  out  3  current state code

Behaviour:
- Reset (reset=0, async): state INIT. pausa, continuar, error_ch and err_cnt are 0. idle, error_full and flush are 0. Hold counter is 0.
- Per-channel flags are combinational from occ:
  - full_i: occ_i == DEPTH
  - af_i: occ_i >= umbral_af
  - ae_i: occ_i <= umbral_ae
  - empty_i: occ_i == 0
- Aggregates: any_full = OR of full_i; all_empty = AND of empty_i.
- State codes: INIT=0, IDLE=1, ACTIVE=2, ERROR=3, RST=4. Codes 5-7 are illegal and go to INIT on the next edge.
- Transitions, evaluated at each edge:
  - INIT: iniciar=1 -> IDLE; else stay.
  - IDLE: any_full -> ERROR; else !all_empty -> ACTIVE; else stay.
  - ACTIVE: any_full -> ERROR; else all_empty -> IDLE; else stay.
  - ERROR: stay for ERR_HOLD cycles, counted from the entry edge, then -> RST.
  - RST: one cycle, then -> IDLE regardless of inputs.
- Moore outputs (idle, error_full, flush, estado) decode the state register directly. Latency: a condition sampled at edge k becomes visible on these outputs immediately after edge k.
- Pause hysteresis, per channel, registered, updated only on edges where the current state is ACTIVE:
  - pausa[i]=0 and af_i -> pausa[i] becomes 1.
  - pausa[i]=1 and ae_i and !af_i -> pausa[i] becomes 0, and continuar[i]=1 for exactly that one cycle.
  - Otherwise pausa[i] holds and continuar[i]=0.
  - Simultaneous af_i and ae_i (misprogrammed thresholds): set wins.
- The ACTIVE->IDLE edge applies the hysteresis rule as well. Since all_empty implies ae_i, any set pausa clears with a continuar pulse.
- On any edge leaving ACTIVE for ERROR, every pausa bit is forced to 0 with no continuar pulse. In INIT, IDLE, ERROR and RST, continuar=0.
- error_ch: on the edge entering ERROR, error_ch |= full vector. It is cleared when err_clear=1, sampled in any state. If capture and err_clear coincide, capture wins.
- err_cnt: increments on every ERROR entry and saturates at 255. Only reset clears it.
- Threshold changes take effect on the next edge. There is no internal buffering.
- Async reset mid-operation, including mid-ERROR or mid-RST, aborts immediately to the reset values above.

Test Plan:
1. Start and idle: reset low then high; iniciar=1 for one cycle with all occ=0 -> estado 0->1, idle=1; occ0=3 -> estado=2, idle=0 one edge later.
2. Hysteresis, DEPTH=16, af=12, ae=4: ramp occ1 0->12 -> pausa[1]=1 after the edge sampling 12. Hold through 11..5. occ1=4 -> pausa[1]=0 with a single-cycle continuar[1]=1. No other bits toggle.
3. Full error: in ACTIVE set occ2=16 and occ3=16 -> error_full=1 for ERR_HOLD+1 cycles (ERROR then RST), flush=1 only in the RST cycle, error_ch=4'b1100, err_cnt=1, all pausa=0, then estado=1.
4. Priority and clear: err_clear=1 on the same edge as ERROR entry -> error_ch captures. Later err_clear alone -> error_ch=0, err_cnt unchanged.
5. Misprogramming: umbral_ae=10, umbral_af=8, occ0=9 -> pausa[0] sets and never clears while occ0 >= 8. After 256 forced errors, err_cnt holds at 255.
6. Async reset asserted mid-ERROR, between clock edges -> all outputs 0 and estado=0 immediately, without waiting for a clock edge.
